fib_responder: RTL and testbench

FIB_RESPONDER -- requirements
Module: fib_responder

---
 rtl/fib_pkg.sv | 17 +
 rtl/fib_responder.sv | 129 ++++++++++++
 tb/tb_fib_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci responder.
package fib_pkg;

   localparam int N_W   = 8;
   localparam int Y_W   = 32;
   localparam int CNT_W = 16;

   localparam int             FIB_MAX_N = 47;
   localparam logic [Y_W-1:0] FIB_SAT   = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } fib_state_t;

endpackage

// File: rtl/fib_responder.sv
// Request/response Fibonacci calculator: one 32-bit adder iterated in CALC.
// Define FIB_MEMO_EN to keep the last result pair and answer n / n+1 in one edge.
module fib_responder
   import fib_pkg::*;
#(
   parameter int MAX_N = FIB_MAX_N
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [N_W-1:0]   req_n,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [Y_W-1:0]   rsp_y,
   output logic             rsp_ovf,
   output logic [CNT_W-1:0] rsp_cnt
);

   fib_state_t         state, state_next;
   logic [Y_W-1:0]     a, b, sum, direct_y;
   logic [N_W-1:0]     count;
   logic               accept, is_ovf, is_direct, last_step, respond;

   assign sum       = a + b;
   assign accept    = req_valid && (state == IDLE);
   assign is_ovf    = req_n > N_W'(MAX_N);
   assign respond   = (state == DONE) && rsp_ready;
   // The accept edge is the first of n edges, so CALC ends one step early.
   assign last_step = (count == N_W'(2));

`ifdef FIB_MEMO_EN
   logic               memo_vld, memo_hit;
   logic [N_W-1:0]     memo_n, calc_n;
   logic [Y_W-1:0]     memo_y0, memo_y1;

   assign memo_hit  = memo_vld && !is_ovf &&
                      ((req_n == memo_n) || (req_n == memo_n + N_W'(1)));
   assign is_direct = is_ovf || (req_n <= N_W'(1)) || memo_hit;

   always_comb begin
      direct_y = Y_W'(req_n);
      if (is_ovf)
         direct_y = FIB_SAT;
      else if (memo_hit)
         direct_y = (req_n == memo_n) ? memo_y0 : memo_y1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         memo_vld <= 1'b0;
         memo_n   <= '0;
         calc_n   <= '0;
         memo_y0  <= '0;
         memo_y1  <= '0;
      end else begin
         if (accept)
            calc_n <= req_n;
         if ((state == CALC) && last_step) begin
            memo_vld <= 1'b1;
            memo_n   <= calc_n;
            memo_y0  <= sum;
            memo_y1  <= sum + b;
         end
      end
   end
`else
   assign is_direct = is_ovf || (req_n <= N_W'(1));

   always_comb begin
      direct_y = Y_W'(req_n);
      if (is_ovf)
         direct_y = FIB_SAT;
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = is_direct ? DONE : CALC;
         CALC:    if (last_step) state_next = DONE;
         DONE:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == DONE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a       <= '0;
         b       <= '0;
         count   <= '0;
         rsp_y   <= '0;
         rsp_ovf <= 1'b0;
         rsp_cnt <= '0;
      end else begin
         if (accept) begin
            rsp_ovf <= is_ovf;
            if (is_direct) begin
               rsp_y <= direct_y;
            end else begin
               a     <= '0;
               b     <= Y_W'(1);
               count <= req_n;
            end
         end else if (state == CALC) begin
            a     <= b;
            b     <= sum;
            count <= count - N_W'(1);
            if (last_step)
               rsp_y <= sum;
         end
         if (respond)
            rsp_cnt <= rsp_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fib_responder.sv
// Self-checking bench for fib_responder: vector table, sweep, random and reset cases.
module tb_fib_responder;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [7:0]  req_n = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_y;
   logic        rsp_ovf;
   logic [15:0] rsp_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

`ifdef FIB_MEMO_EN
   localparam bit MEMO = 1'b1;
`else
   localparam bit MEMO = 1'b0;
`endif
   bit m_vld = 1'b0;
   int m_n = 0;

   typedef struct {
      int          n;
      logic [31:0] y;
      bit          ovf;
      int          hold;
   } vec_t;

   fib_responder dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_n     (req_n),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_ovf   (rsp_ovf),
      .rsp_cnt   (rsp_cnt)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
      end
   endtask

   // Reference value straight from the recurrence, saturated above 47.
   function automatic logic [31:0] fib_ref(input int n);
      longint unsigned x = 0, y = 1, t;
      if (n > 47) return 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         t = x + y;
         x = y;
         y = t;
      end
      return x[31:0];
   endfunction

   function automatic bit memo_hit(input int n);
      return MEMO && m_vld && (n >= 2) && (n <= 47) && ((n == m_n) || (n == m_n + 1));
   endfunction

   function automatic int exp_lat(input int n);
      if ((n > 47) || (n <= 1) || memo_hit(n)) return 1;
      return n;
   endfunction

   task automatic memo_note(input int n, input bit hit);
      if ((n >= 2) && (n <= 47) && !hit) begin
         m_vld = 1'b1;
         m_n   = n;
      end
   endtask

   task automatic run_req(input int n, input int hold, input logic [31:0] y_exp, input bit ovf_exp);
      int lat, lat_exp;
      bit hit;
      hit     = memo_hit(n);
      lat_exp = exp_lat(n);
      @(negedge clock);
      check($sformatf("n=%0d req_ready before accept", n), req_ready, 1);
      req_valid = 1'b1;
      req_n     = 8'(n);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 300) begin
         @(posedge clock);
         #1;
         lat++;
      end
      check($sformatf("n=%0d latency", n), lat, lat_exp);
      check($sformatf("n=%0d rsp_y", n), rsp_y, y_exp);
      check($sformatf("n=%0d rsp_ovf", n), rsp_ovf, ovf_exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clock);
         #1;
         check($sformatf("n=%0d held rsp_valid", n), rsp_valid, 1);
         check($sformatf("n=%0d held rsp_y", n), rsp_y, y_exp);
         check($sformatf("n=%0d held rsp_ovf", n), rsp_ovf, ovf_exp);
         check($sformatf("n=%0d held req_ready", n), req_ready, 0);
         check($sformatf("n=%0d held rsp_cnt", n), rsp_cnt, 16'(exp_cnt));
      end
      @(negedge clock);
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      exp_cnt++;
      check($sformatf("n=%0d rsp_valid after handshake", n), rsp_valid, 0);
      check($sformatf("n=%0d rsp_cnt", n), rsp_cnt, 16'(exp_cnt));
      memo_note(n, hit);
   endtask

   task automatic apply_reset();
      @(posedge clock);
      #2 reset_n = 1'b0;
      m_vld   = 1'b0;
      exp_cnt = 0;
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
   endtask

   initial begin
      vec_t vecs[$];
      int   lat, n, hold;
      bit   seen, hit;

      vecs = '{
         '{10,  32'd55,          1'b0, 0},
         '{0,   32'd0,           1'b0, 0},
         '{1,   32'd1,           1'b0, 0},
         '{2,   32'd1,           1'b0, 0},
         '{47,  32'd2971215073,  1'b0, 0},
         '{48,  32'hFFFF_FFFF,   1'b1, 0},
         '{255, 32'hFFFF_FFFF,   1'b1, 2},
         '{20,  32'd6765,        1'b0, 5},
         '{30,  32'd832040,      1'b0, 0},
         '{31,  32'd1346269,     1'b0, 0},
         '{31,  32'd1346269,     1'b0, 1},
         '{46,  32'd1836311903,  1'b0, 0}
      };

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("reset req_ready", req_ready, 1);
      check("reset rsp_valid", rsp_valid, 0);
      check("reset rsp_y", rsp_y, 0);
      check("reset rsp_ovf", rsp_ovf, 0);
      check("reset rsp_cnt", rsp_cnt, 0);
      #2 reset_n = 1'b1;

      foreach (vecs[i])
         run_req(vecs[i].n, vecs[i].hold, vecs[i].y, vecs[i].ovf);

      // A request held across a response handshake is taken one edge later
      hit = memo_hit(3);
      @(negedge clock);
      req_valid = 1'b1;
      req_n     = 8'd3;
      @(posedge clock);
      #1;
      lat = 1;
      while (!rsp_valid && lat < 300) begin
         @(posedge clock);
         #1;
         lat++;
      end
      check("overlap first rsp_y", rsp_y, 2);
      memo_note(3, hit);
      hit = memo_hit(3);
      @(negedge clock);
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      exp_cnt++;
      check("overlap no accept on handshake edge", req_ready, 1);
      check("overlap rsp_valid low", rsp_valid, 0);
      check("overlap rsp_cnt", rsp_cnt, 16'(exp_cnt));
      @(posedge clock);
      #1;
      check("overlap accept on next edge", req_ready, 0);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 300) begin
         @(posedge clock);
         #1;
         lat++;
      end
      check("overlap second rsp_y", rsp_y, 2);
      memo_note(3, hit);
      @(negedge clock);
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      exp_cnt++;
      check("overlap second rsp_cnt", rsp_cnt, 16'(exp_cnt));

      // Reset in the middle of a calculation abandons it
      @(negedge clock);
      req_valid = 1'b1;
      req_n     = 8'd30;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      repeat (9) @(posedge clock);
      #2 reset_n = 1'b0;
      m_vld   = 1'b0;
      exp_cnt = 0;
      #1;
      check("midcalc reset req_ready", req_ready, 1);
      check("midcalc reset rsp_valid", rsp_valid, 0);
      check("midcalc reset rsp_y", rsp_y, 0);
      check("midcalc reset rsp_ovf", rsp_ovf, 0);
      check("midcalc reset rsp_cnt", rsp_cnt, 0);
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (rsp_valid) seen = 1'b1;
      end
      check("midcalc no response", seen, 0);
      run_req(5, 0, 32'd5, 1'b0);

      // Sweep n=1..46, fifty passes, from a fresh count
      apply_reset();
      for (int pass = 0; pass < 50; pass++)
         for (int k = 1; k <= 46; k++)
            run_req(k, 0, fib_ref(k), 1'b0);
      check("sweep rsp_cnt", rsp_cnt, 2300);

      // Random requests with random backpressure
      for (int r = 0; r < 30; r++) begin
         n    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(48, 255)) : int'($urandom_range(0, 47));
         hold = int'($urandom_range(0, 3));
         run_req(n, hold, fib_ref(n), n > 47);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
